sevenseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares a single combinational BCD-to-seven-segment decoder (common cathode, `in[3:0]` → `out[6:0]`) across `NUM_DIGITS` digits. It latches a packed BCD word, steps through the digits with a blanking gap between each, and drives the decoder input, the segment lines and the per-digit enables. It sits between the numeric datapath and the display pins, and the decoder itself sits outside it.

---
 rtl/sevenseg_pkg.sv | 20 ++
 rtl/sevenseg_timebase.sv | 33 +++
 rtl/sevenseg_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types, segment constants and helpers for the seven-segment scan controller.
package sevenseg_pkg;

  localparam int MAX_DIGITS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  // One-hot digit enable for a digit index; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    onehot = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/sevenseg_timebase.sv
// Phase timer: a down-counter reloaded with the length of the phase being entered.
// tick marks the last cycle of the current phase (count at zero).
module sevenseg_timebase
  import sevenseg_pkg::*;
#(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic on_phase,
  output logic tick
);

  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  logic [CW-1:0] count_r;

  assign tick = (count_r == {CW{1'b0}});

  // Count down; at terminal count reload with the length of the opposite phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (tick) begin
      count_r <= on_phase ? CW'(BLANK_CYCLES - 1) : CW'(ON_CYCLES - 1);
    end else begin
      count_r <= count_r - CW'(1);
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller. Holds a double-buffered BCD
// word, walks the digits with a blanking gap before each one, feeds the shared
// external decoder and masks its output (dash for non-BCD, leading-zero blank).
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_en,
  input  logic [6:0]              dec_seg,
  output logic [3:0]              dec_bcd,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    pending,
  output logic                    bad_digit
);

  localparam int              IW       = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_t               state_r, state_next_s;
  logic [IW-1:0]             idx_r, idx_next_s, idx_inc_s;
  logic [4*NUM_DIGITS-1:0]   shadow_r, active_r, active_next_s;
  logic                      lz_en_r;
  logic [IW-1:0]             hi_r, hi_next_s;
  logic                      bad_next_s;
  logic                      tick_s, boundary_s;
  logic [3:0]                nibble_cur_s, nibble_next_s;
  logic [6:0]                mask_s, seg_next_s;
  logic [NUM_DIGITS-1:0]     dig_en_next_s;
  logic [3:0]                dec_bcd_next_s;

  sevenseg_timebase #(
    .ON_CYCLES    (ON_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .on_phase (state_r == ON),
    .tick     (tick_s)
  );

  // The frame ends on the last lit cycle of the highest digit.
  assign boundary_s    = (state_r == ON) && tick_s && (idx_r == LAST_IDX);
  assign active_next_s = (boundary_s && pending) ? shadow_r : active_r;
  assign idx_inc_s     = (idx_r == LAST_IDX) ? {IW{1'b0}} : idx_r + IW'(1);
  assign nibble_cur_s  = active_r[{idx_r, 2'b00} +: 4];
  assign nibble_next_s = active_next_s[{idx_inc_s, 2'b00} +: 4];

  // Highest nonzero digit and non-BCD flag of the word about to become active.
  always_comb begin
    hi_next_s  = {IW{1'b0}};
    bad_next_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hi_next_s  = (active_next_s[4*i +: 4] != 4'd0) ? IW'(i) : hi_next_s;
      bad_next_s = bad_next_s | (active_next_s[4*i +: 4] > BCD_MAX);
    end
  end

  // Segment mask for the digit about to light: dash beats leading-zero blanking.
  always_comb begin
    if (nibble_cur_s > BCD_MAX) begin
      mask_s = SEG_DASH;
    end else if (lz_en_r && (idx_r > hi_r) && (idx_r != {IW{1'b0}})) begin
      mask_s = SEG_OFF;
    end else begin
      mask_s = dec_seg;
    end
  end

  // Next state and next registered outputs of the scan FSM.
  always_comb begin
    state_next_s   = state_r;
    idx_next_s     = idx_r;
    seg_next_s     = seg;
    dig_en_next_s  = dig_en;
    dec_bcd_next_s = dec_bcd;
    case (state_r)
      BLANK: begin
        if (tick_s) begin
          state_next_s  = ON;
          seg_next_s    = mask_s;
          dig_en_next_s = NUM_DIGITS'(onehot(3'(idx_r)));
        end else begin
          seg_next_s    = SEG_OFF;
          dig_en_next_s = {NUM_DIGITS{1'b0}};
        end
      end
      ON: begin
        if (tick_s) begin
          state_next_s   = BLANK;
          idx_next_s     = idx_inc_s;
          seg_next_s     = SEG_OFF;
          dig_en_next_s  = {NUM_DIGITS{1'b0}};
          dec_bcd_next_s = nibble_next_s;
        end else begin
          seg_next_s    = seg;
          dig_en_next_s = dig_en;
        end
      end
      default: begin
        state_next_s   = BLANK;
        idx_next_s     = {IW{1'b0}};
        seg_next_s     = SEG_OFF;
        dig_en_next_s  = {NUM_DIGITS{1'b0}};
        dec_bcd_next_s = 4'd0;
      end
    endcase
  end

  // Scan FSM state, digit index and the pin-facing output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BLANK;
      idx_r   <= {IW{1'b0}};
      seg     <= SEG_OFF;
      dig_en  <= {NUM_DIGITS{1'b0}};
      dec_bcd <= 4'd0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      seg     <= seg_next_s;
      dig_en  <= dig_en_next_s;
      dec_bcd <= dec_bcd_next_s;
    end
  end

  // Double buffer: load writes shadow, the frame boundary commits it and
  // re-samples the leading-zero enable and per-frame digit flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r  <= {(4*NUM_DIGITS){1'b0}};
      active_r  <= {(4*NUM_DIGITS){1'b0}};
      pending   <= 1'b0;
      lz_en_r   <= 1'b0;
      hi_r      <= {IW{1'b0}};
      bad_digit <= 1'b0;
    end else begin
      if (load) begin
        shadow_r <= value;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (boundary_s) begin
        pending <= 1'b0;
      end
      if (boundary_s) begin
        active_r  <= active_next_s;
        lz_en_r   <= lz_en;
        hi_r      <= hi_next_s;
        bad_digit <= bad_next_s;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with a behavioural BCD decoder attached.
module tb_sevenseg_scan_ctrl;

  localparam int ND  = 4;
  localparam int ONC = 4;
  localparam int BLC = 1;
  localparam int DP  = BLC + ONC;
  localparam int FP  = ND * DP;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] SX = 7'b0000000;
  localparam logic [6:0] SD = 7'b1000000;

  logic        clk = 1'b0;
  logic        rst, load, lz_en;
  logic [15:0] value;
  logic [6:0]  dec_seg, seg;
  logic [3:0]  dec_bcd, dig_en;
  logic        pending, bad_digit;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  logic [79:0]  gd;
  logic [139:0] gs;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .ON_CYCLES    (ONC),
    .BLANK_CYCLES (BLC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .lz_en     (lz_en),
    .dec_seg   (dec_seg),
    .dec_bcd   (dec_bcd),
    .seg       (seg),
    .dig_en    (dig_en),
    .pending   (pending),
    .bad_digit (bad_digit)
  );

  // Common-cathode BCD decoder, {g,f,e,d,c,b,a}.
  always_comb begin
    case (dec_bcd)
      4'd0: dec_seg = 7'b0111111;
      4'd1: dec_seg = 7'b0000110;
      4'd2: dec_seg = 7'b1011011;
      4'd3: dec_seg = 7'b1001111;
      4'd4: dec_seg = 7'b1100110;
      4'd5: dec_seg = 7'b1101101;
      4'd6: dec_seg = 7'b1111101;
      4'd7: dec_seg = 7'b0000111;
      4'd8: dec_seg = 7'b1111111;
      4'd9: dec_seg = 7'b1101111;
      default: dec_seg = 7'b0000000;
    endcase
  end

  task automatic step();
    @(negedge clk);
    t = t + 1;
  endtask

  task automatic goto_phase(input int ph);
    while ((t % FP) != ph) step();
  endtask

  // Expected {dig_en, seg} at frame position q, digit segments packed {d3,d2,d1,d0}.
  function automatic logic [10:0] expect_at(input int q, input logic [27:0] digs);
    logic [3:0] one;
    one = 4'b0001;
    if ((q % DP) == 0) return 11'd0;
    return {one << (q / DP), digs[(q / DP) * 7 +: 7]};
  endfunction

  task automatic capture_frame(output logic [79:0] d, output logic [139:0] s);
    d = 80'd0;
    s = 140'd0;
    goto_phase(0);
    for (int q = 0; q < FP; q++) begin
      d[q*4 +: 4] = dig_en;
      s[q*7 +: 7] = seg;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; lz_en = 1'b0; value = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t = 0;
    n_tests++;
    if ({dig_en, seg, dec_bcd, pending, bad_digit} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset dig_en=%b seg=%b dec_bcd=%h pending=%b bad=%b, expected all 0",
               dig_en, seg, dec_bcd, pending, bad_digit);
    end
  endtask

  task automatic test_scan_zero();
    for (int f = 0; f < 2; f++) begin
      capture_frame(gd, gs);
      for (int q = 0; q < FP; q++) begin
        n_tests++;
        if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {S0, S0, S0, S0})) begin
          n_fail++;
          $display("FAIL scan_zero f=%0d q=%0d got %b_%b expected %b", f, q, gd[q*4 +: 4],
                   gs[q*7 +: 7], expect_at(q, {S0, S0, S0, S0}));
        end
      end
    end
  endtask

  task automatic test_load();
    goto_phase(7);
    load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0; value = 16'hFFFF;
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pending_rise got %b expected 1", pending); end
    goto_phase(FP - 1);
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pending_hold got %b expected 1", pending); end
    step();
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL load_pending_fall got %b expected 0", pending); end
    capture_frame(gd, gs);
    for (int q = 0; q < FP; q++) begin
      n_tests++;
      if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {S1, S2, S3, S4})) begin
        n_fail++;
        $display("FAIL load_1234 q=%0d got %b_%b expected %b", q, gd[q*4 +: 4], gs[q*7 +: 7],
                 expect_at(q, {S1, S2, S3, S4}));
      end
    end
  endtask

  task automatic test_lz();
    lz_en = 1'b1;
    goto_phase(5);
    load = 1'b1; value = 16'h0070;
    step();
    load = 1'b0;
    capture_frame(gd, gs);
    for (int q = 0; q < FP; q++) begin
      n_tests++;
      if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {SX, SX, S7, S0})) begin
        n_fail++;
        $display("FAIL lz_0070 q=%0d got %b_%b expected %b", q, gd[q*4 +: 4], gs[q*7 +: 7],
                 expect_at(q, {SX, SX, S7, S0}));
      end
    end
  endtask

  task automatic test_bad_digit();
    goto_phase(5);
    load = 1'b1; value = 16'h00A5;
    step();
    load = 1'b0;
    goto_phase(FP - 1);
    n_tests++;
    if (bad_digit !== 1'b0) begin n_fail++; $display("FAIL bad_before got %b expected 0", bad_digit); end
    step();
    n_tests++;
    if (bad_digit !== 1'b1) begin n_fail++; $display("FAIL bad_set got %b expected 1", bad_digit); end
    capture_frame(gd, gs);
    for (int q = 0; q < FP; q++) begin
      n_tests++;
      if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {SX, SX, SD, S5})) begin
        n_fail++;
        $display("FAIL bad_00A5 q=%0d got %b_%b expected %b", q, gd[q*4 +: 4], gs[q*7 +: 7],
                 expect_at(q, {SX, SX, SD, S5}));
      end
    end
    goto_phase(3);
    load = 1'b1; value = 16'h0005;
    step();
    load = 1'b0;
    goto_phase(FP - 1);
    n_tests++;
    if (bad_digit !== 1'b1) begin n_fail++; $display("FAIL bad_hold got %b expected 1", bad_digit); end
    step();
    n_tests++;
    if (bad_digit !== 1'b0) begin n_fail++; $display("FAIL bad_clear got %b expected 0", bad_digit); end
    capture_frame(gd, gs);
    for (int q = 0; q < FP; q++) begin
      n_tests++;
      if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {SX, SX, SX, S5})) begin
        n_fail++;
        $display("FAIL lz_0005 q=%0d got %b_%b expected %b", q, gd[q*4 +: 4], gs[q*7 +: 7],
                 expect_at(q, {SX, SX, SX, S5}));
      end
    end
  endtask

  task automatic test_back_to_back();
    lz_en = 1'b0;
    goto_phase(2);
    load = 1'b1; value = 16'h1111;
    step();
    load = 1'b0;
    goto_phase(10);
    load = 1'b1; value = 16'h2222;
    step();
    load = 1'b0; value = 16'h0000;
    for (int f = 0; f < 2; f++) begin
      capture_frame(gd, gs);
      for (int q = 0; q < FP; q++) begin
        n_tests++;
        if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {S2, S2, S2, S2})) begin
          n_fail++;
          $display("FAIL back_to_back f=%0d q=%0d got %b_%b expected %b", f, q, gd[q*4 +: 4],
                   gs[q*7 +: 7], expect_at(q, {S2, S2, S2, S2}));
        end
      end
    end
  endtask

  task automatic test_load_on_boundary();
    goto_phase(5);
    load = 1'b1; value = 16'h3333;
    step();
    load = 1'b0;
    goto_phase(FP - 1);
    load = 1'b1; value = 16'h4444;
    step();
    load = 1'b0;
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL boundary_load_pending got %b expected 1", pending); end
    capture_frame(gd, gs);
    for (int q = 0; q < FP; q++) begin
      n_tests++;
      if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {S3, S3, S3, S3})) begin
        n_fail++;
        $display("FAIL boundary_3333 q=%0d got %b_%b expected %b", q, gd[q*4 +: 4], gs[q*7 +: 7],
                 expect_at(q, {S3, S3, S3, S3}));
      end
    end
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL boundary_pending_clear got %b expected 0", pending); end
    capture_frame(gd, gs);
    for (int q = 0; q < FP; q++) begin
      n_tests++;
      if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {S4, S4, S4, S4})) begin
        n_fail++;
        $display("FAIL boundary_4444 q=%0d got %b_%b expected %b", q, gd[q*4 +: 4], gs[q*7 +: 7],
                 expect_at(q, {S4, S4, S4, S4}));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    goto_phase(3);
    load = 1'b1; value = 16'h5678;
    step();
    load = 1'b0;
    goto_phase(12);
    n_tests++;
    if ({pending, dig_en} !== 5'b1_0100) begin
      n_fail++;
      $display("FAIL pre_reset pending=%b dig_en=%b expected 1 0100", pending, dig_en);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if ({dig_en, seg, dec_bcd, pending, bad_digit} !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_reset dig_en=%b seg=%b dec_bcd=%h pending=%b bad=%b, expected all 0",
               dig_en, seg, dec_bcd, pending, bad_digit);
    end
    rst = 1'b0;
    t = 0;
    for (int f = 0; f < 2; f++) begin
      capture_frame(gd, gs);
      for (int q = 0; q < FP; q++) begin
        n_tests++;
        if ({gd[q*4 +: 4], gs[q*7 +: 7]} !== expect_at(q, {S0, S0, S0, S0})) begin
          n_fail++;
          $display("FAIL after_reset f=%0d q=%0d got %b_%b expected %b", f, q, gd[q*4 +: 4],
                   gs[q*7 +: 7], expect_at(q, {S0, S0, S0, S0}));
        end
      end
    end
    n_tests++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL after_reset_pending got %b expected 0", pending); end
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_load();
    test_lz();
    test_bad_digit();
    test_back_to_back();
    test_load_on_boundary();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
